// File: rtl/sci_uart_tx.sv
// SCI transmit path: byte FIFO fed by register writes, drained by an 8N1 serializer.
// The divisor is latched per frame so mid-frame baud_div changes never distort a character.
module sci_uart_tx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk30,
  input  logic                            reset,
  input  logic [7:0]                      in_data,
  input  logic                            in_write,
  input  logic [15:0]                     baud_div,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  input  logic                            overflow_clear,
  output logic [1:0]                      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     bit_len;
  logic [15:0]     period_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;

  logic            fifo_empty;
  logic            fifo_full;
  logic            bit_end;
  logic            pop;
  logic            push;
  logic            drop;
  logic [15:0]     baud_eff;

  // Handshake: in_write is a one-cycle strobe with no ready; a byte offered to a
  // full FIFO is accepted only if the serializer pops in that same cycle, else dropped.
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == CW'(FIFO_DEPTH));
    bit_end    = (period_cnt == bit_len - 16'd1);
    pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    push       = in_write && (!fifo_full || pop);
    drop       = in_write && fifo_full && !pop;
    baud_eff   = (baud_div < 16'd2) ? 16'd2 : baud_div;
  end

  always_ff @(posedge clk30) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk30) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

  // txd is registered from the current state, so the line trails the FSM by one cycle;
  // every bit still lasts exactly bit_len cycles.
  always_ff @(posedge clk30) begin
    if (reset) begin
      state      <= IDLE;
      txd        <= 1'b1;
      bit_len    <= 16'd2;
      period_cnt <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
    end else begin
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shift_q[0];
        default: txd <= 1'b1;
      endcase

      if (state == IDLE || bit_end) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= START;
            shift_q <= mem[rd_ptr];
            bit_len <= baud_eff;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              state   <= START;
              shift_q <= mem[rd_ptr];
              bit_len <= baud_eff;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;
  assign dbg_state  = state;

endmodule

// File: doc/sci_uart_tx.md
SCI_UART_TX -- requirements
Module: sci_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, byte entries buffered between the bytestream sink and the serializer; power of two, 2..256.
REQ-002 clk30  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_data  input  8  byte from the microcontroller SCI data register write (bytestream sink data).
REQ-005 in_write  input  1  single-cycle strobe; in_data is valid when high; there is no back-pressure.
REQ-006 baud_div  input  16  clk30 cycles per serial bit.
REQ-007 txd  output  1  serial line, idle high.
REQ-008 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.
REQ-010 overflow  output  1  sticky flag: a byte was dropped.
REQ-011 overflow_clear  input  1  clears overflow.

Function
REQ-012 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-013 FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START: FIFO non-empty.
- START->DATA: after 1 bit period.
- DATA->STOP: after 8 bit periods.
- STOP->START: after 1 bit period if FIFO non-empty, otherwise STOP->IDLE.
REQ-014 Bit period SHALL be max(baud_div,2) cycles; baud_div SHALL be latched on entry to START and held constant for the whole frame.
REQ-015 Bit counter SHALL count 0..7 in DATA; the period counter reloads at every bit boundary with no cycle gaps, so a frame lasts exactly 10 bit periods.
REQ-016 Back-to-back frames SHALL have no idle gap: the next start bit follows the stop bit directly.
REQ-017 Latency: in_write sampled at edge N, FIFO empty, FSM in IDLE -> txd low from edge N+2.
REQ-018 The FIFO pop SHALL occur on the IDLE->START or STOP->START transition; the popped byte is copied into the shift register.
REQ-019 A write to a full FIFO SHALL drop the byte and set overflow, unless a pop occurs in the same cycle; in that case the write is accepted and fifo_count is unchanged.
REQ-020 Write and pop in the same cycle on a non-full FIFO: fifo_count SHALL be unchanged.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 overflow_clear and a concurrent overflow event: set SHALL win.
REQ-023 txd SHALL be registered (glitch-free) and SHALL be 1 in IDLE and STOP.
REQ-024 busy SHALL equal (state != IDLE) or (fifo_count != 0).

Reset
REQ-025 On reset the block SHALL go to IDLE with txd=1, busy=0, fifo_count=0, overflow=0, FIFO pointers=0, counters=0 and latched divisor=2.
REQ-026 Reset mid-frame SHALL abort the frame with txd=1 at the next edge and SHALL discard all queued bytes.
REQ-027 in_write asserted during reset SHALL be ignored.

Verification
REQ-028 baud_div=4, write 0xA5 -> txd: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy falls after 40 cycles.
REQ-029 baud_div=3, write 0x00 then 0xFF on consecutive cycles -> two contiguous 30-cycle frames with no gap; fifo_count peaks at 1.
REQ-030 FIFO_DEPTH=16, baud_div=100, 20 writes in a burst -> first byte sent, 16 queued, 3 dropped; overflow=1; overflow_clear -> overflow=0; all 17 accepted bytes appear on txd in order.
REQ-031 baud_div changed from 8 to 2 during a frame -> current frame keeps the 8-cycle bit period; next frame uses 2; baud_div=0 or 1 -> 2-cycle bits.
REQ-032 reset asserted in DATA bit 3 with 5 bytes queued -> txd=1 at the next edge; busy=0 and fifo_count=0; a write after reset transmits only the new byte.
